// File: rtl/csr_access_seq_pkg.sv
// CSR sequencer shared definitions: funct3 encodings, CSR op codes, FSM states, well-known addresses.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Package csr_pkg is imported by every file of the csr_access_seq slice.
package csr_pkg;

  // funct3 encodings of the Zicsr instructions
  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // op codes understood by the CSR register unit
  localparam logic [1:0] CSR_OP_RW = 2'b00;
  localparam logic [1:0] CSR_OP_RS = 2'b01;
  localparam logic [1:0] CSR_OP_RC = 2'b10;

  // read-only counter addresses
  localparam logic [11:0] CSR_CYCLE  = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH = 12'hC80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/csr_access_seq_if.sv
// Bundle of the request, response and CSR-unit signals of the CSR access sequencer.
// Latency: n/a (wires only).
// Backpressure: req via req_valid_i/req_ready_o, rsp via rsp_valid_o/rsp_ready_i.
//
// Modports: slave = sequencer side, master = decode/execute + CSR unit side.
interface csr_access_seq_if #(
  parameter int CSR_ADDR_W = 12,
  parameter int DATA_W     = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [2:0]            req_funct3_i;
  logic [CSR_ADDR_W-1:0] req_csr_addr_i;
  logic [4:0]            req_rs1_field_i;
  logic [DATA_W-1:0]     req_rs1_data_i;
  logic [4:0]            req_rd_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [4:0]            rsp_rd_o;
  logic [DATA_W-1:0]     rsp_rdata_o;
  logic                  rsp_wen_o;
  logic                  rsp_illegal_o;

  logic [CSR_ADDR_W-1:0] csr_addr_o;
  logic [DATA_W-1:0]     csr_wdata_o;
  logic [1:0]            csr_op_o;
  logic                  csr_we_o;
  logic [DATA_W-1:0]     csr_rdata_i;

  modport slave (
    input  req_valid_i, req_funct3_i, req_csr_addr_i, req_rs1_field_i, req_rs1_data_i, req_rd_i,
    input  rsp_ready_i, csr_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rd_o, rsp_rdata_o, rsp_wen_o, rsp_illegal_o,
    output csr_addr_o, csr_wdata_o, csr_op_o, csr_we_o
  );

  modport master (
    output req_valid_i, req_funct3_i, req_csr_addr_i, req_rs1_field_i, req_rs1_data_i, req_rd_i,
    output rsp_ready_i, csr_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rd_o, rsp_rdata_o, rsp_wen_o, rsp_illegal_o,
    input  csr_addr_o, csr_wdata_o, csr_op_o, csr_we_o
  );
endinterface

// File: rtl/csr_access_seq_decode.sv
// Combinational funct3/rs1 decode: CSR op code, immediate select, write-needed and illegal flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: funct3_i, rs1_field_i in; op_o, imm_sel_o, write_needed_o, illegal_o out.
module csr_decode
  import csr_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [4:0] rs1_field_i,
  output logic [1:0] op_o,
  output logic       imm_sel_o,
  output logic       write_needed_o,
  output logic       illegal_o
);

  always_comb begin
    op_o = CSR_OP_RW;
    unique case (funct3_i[1:0])
      2'b10:   op_o = CSR_OP_RS;
      2'b11:   op_o = CSR_OP_RC;
      default: op_o = CSR_OP_RW;
    endcase
  end

  assign imm_sel_o      = funct3_i[2];
  // RW/RWI always write; set/clear forms write only with a nonzero rs1/zimm field
  assign write_needed_o = (funct3_i[1:0] == 2'b01) || (rs1_field_i != 5'd0);
  assign illegal_o      = (funct3_i[1:0] == 2'b00);

endmodule

// File: rtl/csr_access_seq.sv
// CSR access sequencer: runs one CSR instruction as read-old-value then optional single write strobe.
// Latency: accept-to-rsp_valid 3 cycles with write, 2 without, 1 for illegal funct3.
// Backpressure: one request in flight; rsp_ready_i low holds RESP and keeps req_ready_o low.
//
// Ports: clk_i, rst_ni (async, active-low), bus (csr_access_seq_if.slave).
// Option: CSR_RO_CHECK_EN flags write-needed accesses to addr[11:10]==2'b11 as illegal in READ.
module csr_access_seq
  import csr_pkg::*;
#(
  parameter int CSR_ADDR_W = 12,
  parameter int DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  csr_access_seq_if.slave   bus
);

  state_e                state_q;
  logic                  rdy_q;
  logic [2:0]            funct3_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [4:0]            rs1_q;
  logic [DATA_W-1:0]     rs1_data_q;
  logic [4:0]            rd_q;
  logic [DATA_W-1:0]     old_q;

  // decode looks at the incoming request while idle, at the latched one afterwards
  logic [2:0] dec_f3;
  logic [4:0] dec_rs1;
  logic [1:0] dec_op;
  logic       dec_imm;
  logic       dec_wr;
  logic       dec_ill;
  logic       ro_fail;

  assign dec_f3  = (state_q == ST_IDLE) ? bus.req_funct3_i    : funct3_q;
  assign dec_rs1 = (state_q == ST_IDLE) ? bus.req_rs1_field_i : rs1_q;

  csr_decode u_dec (
    .funct3_i       (dec_f3),
    .rs1_field_i    (dec_rs1),
    .op_o           (dec_op),
    .imm_sel_o      (dec_imm),
    .write_needed_o (dec_wr),
    .illegal_o      (dec_ill)
  );

`ifdef CSR_RO_CHECK_EN
  assign ro_fail = dec_wr && (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);
`else
  assign ro_fail = 1'b0;
`endif

  assign bus.req_ready_o = (state_q == ST_IDLE) && rdy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= ST_IDLE;
      rdy_q             <= 1'b0;
      funct3_q          <= '0;
      addr_q            <= '0;
      rs1_q             <= '0;
      rs1_data_q        <= '0;
      rd_q              <= '0;
      old_q             <= '0;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_rd_o      <= '0;
      bus.rsp_rdata_o   <= '0;
      bus.rsp_wen_o     <= 1'b0;
      bus.rsp_illegal_o <= 1'b0;
      bus.csr_addr_o    <= '0;
      bus.csr_wdata_o   <= '0;
      bus.csr_op_o      <= '0;
      bus.csr_we_o      <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid_i && bus.req_ready_o) begin
            funct3_q   <= bus.req_funct3_i;
            addr_q     <= bus.req_csr_addr_i;
            rs1_q      <= bus.req_rs1_field_i;
            rs1_data_q <= bus.req_rs1_data_i;
            rd_q       <= bus.req_rd_i;
            if (dec_ill) begin
              // reserved funct3: answer immediately without touching the CSR unit
              state_q           <= ST_RESP;
              bus.rsp_valid_o   <= 1'b1;
              bus.rsp_rd_o      <= bus.req_rd_i;
              bus.rsp_rdata_o   <= '0;
              bus.rsp_wen_o     <= 1'b0;
              bus.rsp_illegal_o <= 1'b1;
            end else begin
              state_q        <= ST_READ;
              bus.csr_addr_o <= bus.req_csr_addr_i;
            end
          end
        end
        ST_READ: begin
          // csr_rdata_i is only trusted here; later changes (counters) are ignored
          old_q <= bus.csr_rdata_i;
          if (dec_wr && !ro_fail) begin
            state_q         <= ST_WRITE;
            bus.csr_we_o    <= 1'b1;
            bus.csr_op_o    <= dec_op;
            bus.csr_wdata_o <= dec_imm ? {{(DATA_W-5){1'b0}}, rs1_q} : rs1_data_q;
          end else begin
            state_q           <= ST_RESP;
            bus.csr_addr_o    <= '0;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_rd_o      <= rd_q;
            bus.rsp_rdata_o   <= ro_fail ? '0 : bus.csr_rdata_i;
            bus.rsp_wen_o     <= !ro_fail && (rd_q != 5'd0);
            bus.rsp_illegal_o <= ro_fail;
          end
        end
        ST_WRITE: begin
          state_q           <= ST_RESP;
          bus.csr_we_o      <= 1'b0;
          bus.csr_op_o      <= '0;
          bus.csr_wdata_o   <= '0;
          bus.csr_addr_o    <= '0;
          bus.rsp_valid_o   <= 1'b1;
          bus.rsp_rd_o      <= rd_q;
          bus.rsp_rdata_o   <= old_q;
          bus.rsp_wen_o     <= (rd_q != 5'd0);
          bus.rsp_illegal_o <= 1'b0;
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            state_q           <= ST_IDLE;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_rd_o      <= '0;
            bus.rsp_rdata_o   <= '0;
            bus.rsp_wen_o     <= 1'b0;
            bus.rsp_illegal_o <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_seq.sv
// Self-checking bench for csr_access_seq: directed vector table plus backpressure and reset corner cases.
// Latency: n/a.
// Backpressure: bench drives rsp_ready_i low to hold RESP.
module tb_csr_access_seq;
  import csr_pkg::*;

`ifdef CSR_RO_CHECK_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  csr_access_seq_if #(.CSR_ADDR_W(12), .DATA_W(32)) bus ();

  csr_access_seq #(.CSR_ADDR_W(12), .DATA_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  rs1f;
    logic [31:0] rs1d;
    logic [4:0]  rd;
    logic [31:0] crd;
    int          lat;
    int          we;
    logic [1:0]  op;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        wen;
    logic        ill;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // write-needed access to a read-only address when the check is built in
  function automatic vec_t as_ro_illegal(input vec_t v);
    vec_t r;
    r = v;
    r.lat = 2; r.we = 0; r.rdata = 32'h0; r.wen = 1'b0; r.ill = 1'b1;
    return r;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int cyc;
    int we_cnt;
    n = 0;
    while (!bus.req_ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("v%0d req_ready", idx), {31'b0, bus.req_ready_o}, 32'd1);
    bus.req_funct3_i    = v.f3;
    bus.req_csr_addr_i  = v.addr;
    bus.req_rs1_field_i = v.rs1f;
    bus.req_rs1_data_i  = v.rs1d;
    bus.req_rd_i        = v.rd;
    bus.csr_rdata_i     = v.crd;
    bus.req_valid_i     = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    cyc = 1;
    we_cnt = 0;
    chk($sformatf("v%0d csr_addr_c1", idx), {20'b0, bus.csr_addr_o}, (v.lat == 1) ? 32'h0 : {20'b0, v.addr});
    while (cyc <= 8) begin
      if (bus.csr_we_o) begin
        we_cnt++;
        chk($sformatf("v%0d op", idx), {30'b0, bus.csr_op_o}, {30'b0, v.op});
        chk($sformatf("v%0d wdata", idx), bus.csr_wdata_o, v.wd);
        // a moving read value during WRITE must not reach the response
        bus.csr_rdata_i = 32'hDEAD_BEEF;
      end
      if (bus.rsp_valid_o) break;
      @(posedge clk); #1; cyc++;
    end
    chk($sformatf("v%0d latency", idx), cyc, v.lat);
    chk($sformatf("v%0d we_pulses", idx), we_cnt, v.we);
    chk($sformatf("v%0d rdata", idx), bus.rsp_rdata_o, v.rdata);
    chk($sformatf("v%0d rd", idx), {27'b0, bus.rsp_rd_o}, {27'b0, v.rd});
    chk($sformatf("v%0d wen", idx), {31'b0, bus.rsp_wen_o}, {31'b0, v.wen});
    chk($sformatf("v%0d illegal", idx), {31'b0, bus.rsp_illegal_o}, {31'b0, v.ill});
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    chk($sformatf("v%0d rsp_drop", idx), {31'b0, bus.rsp_valid_o}, 32'd0);
    chk($sformatf("v%0d idle_after", idx), {31'b0, bus.req_ready_o}, 32'd1);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;

    //          f3      addr        rs1f   rs1d          rd     crd           lat we op     wd            rdata         wen   ill
    vec[0] = '{CSRRW,  CSR_CYCLE,  5'd7,  32'h0000_1234, 5'd5, 32'h0000_0010, 3, 1, 2'b00, 32'h0000_1234, 32'h0000_0010, 1'b1, 1'b0};
    vec[1] = '{CSRRS,  12'h300,    5'd0,  32'h0000_FFFF, 5'd3, 32'h0000_ABCD, 2, 0, 2'b00, 32'h0,        32'h0000_ABCD, 1'b1, 1'b0};
    vec[2] = '{CSRRCI, 12'h340,    5'h1F, 32'h0000_5555, 5'd0, 32'h0000_0F0F, 3, 1, 2'b10, 32'h0000_001F, 32'h0000_0F0F, 1'b0, 1'b0};
    vec[3] = '{3'b100, 12'h305,    5'd3,  32'h0000_0001, 5'd8, 32'h0000_0077, 1, 0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1};
    vec[4] = '{CSRRSI, 12'h341,    5'd0,  32'h0000_0000, 5'd9, 32'h0000_1111, 2, 0, 2'b00, 32'h0,        32'h0000_1111, 1'b1, 1'b0};
    vec[5] = '{CSRRWI, 12'h305,    5'd0,  32'h0000_9999, 5'd2, 32'h0000_2222, 3, 1, 2'b00, 32'h0,        32'h0000_2222, 1'b1, 1'b0};
    vec[6] = '{CSRRS,  12'h300,    5'd4,  32'h0000_00F0, 5'd1, 32'h0000_0003, 3, 1, 2'b01, 32'h0000_00F0, 32'h0000_0003, 1'b1, 1'b0};
    vec[7] = '{CSRRC,  12'h300,    5'd0,  32'h0000_00F0, 5'd1, 32'h0000_0044, 2, 0, 2'b00, 32'h0,        32'h0000_0044, 1'b1, 1'b0};
    vec[8] = '{CSRRW,  CSR_CYCLEH, 5'd1,  32'h0000_00AA, 5'd6, 32'h0000_0005, 3, 1, 2'b00, 32'h0000_00AA, 32'h0000_0005, 1'b1, 1'b0};
    vec[9] = '{3'b000, 12'h300,    5'd2,  32'h0000_0001, 5'd4, 32'h0000_0066, 1, 0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1};
    if (RO) begin
      vec[0] = as_ro_illegal(vec[0]);
      vec[8] = as_ro_illegal(vec[8]);
    end

    // reset: all outputs low, ready only after the first edge past release
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_funct3_i = '0; bus.req_csr_addr_i = '0;
    bus.req_rs1_field_i = '0; bus.req_rs1_data_i = '0; bus.req_rd_i = '0;
    bus.rsp_ready_i = 1'b0; bus.csr_rdata_i = '0;
    #12;
    chk("rst req_ready", {31'b0, bus.req_ready_o}, 32'd0);
    chk("rst rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    chk("rst csr_we", {31'b0, bus.csr_we_o}, 32'd0);
    chk("rst csr_addr", {20'b0, bus.csr_addr_o}, 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata_o, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel req_ready_pre", {31'b0, bus.req_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk("rel req_ready_post", {31'b0, bus.req_ready_o}, 32'd1);

    for (int i = 0; i < 10; i++) run_vec(i, vec[i]);

    // response backpressure: hold 4 cycles with a competing request offered
    bus.req_funct3_i = CSRRS; bus.req_csr_addr_i = 12'h300; bus.req_rs1_field_i = 5'd1;
    bus.req_rs1_data_i = 32'h2; bus.req_rd_i = 5'd4; bus.csr_rdata_i = 32'h99;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!bus.rsp_valid_o && n < 10) begin
      bus.req_valid_i = 1'b0;
      @(posedge clk); #1; n++;
    end
    chk("bp latency", n, 3);
    bus.req_valid_i = 1'b1;
    bus.req_rd_i = 5'd17;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d rsp_valid", k), {31'b0, bus.rsp_valid_o}, 32'd1);
      chk($sformatf("bp%0d rdata", k), bus.rsp_rdata_o, 32'h99);
      chk($sformatf("bp%0d rd", k), {27'b0, bus.rsp_rd_o}, 32'd4);
      chk($sformatf("bp%0d req_ready", k), {31'b0, bus.req_ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    chk("bp idle", {31'b0, bus.req_ready_o}, 32'd1);
    chk("bp rsp_drop", {31'b0, bus.rsp_valid_o}, 32'd0);

    // reset during WRITE: strobe drops at once, transaction vanishes
    bus.req_funct3_i = CSRRW; bus.req_csr_addr_i = 12'h300; bus.req_rs1_field_i = 5'd1;
    bus.req_rs1_data_i = 32'h55; bus.req_rd_i = 5'd7; bus.csr_rdata_i = 32'h1;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("mr we_in_write", {31'b0, bus.csr_we_o}, 32'd1);
    rst_n = 1'b0; #1;
    chk("mr we_dropped", {31'b0, bus.csr_we_o}, 32'd0);
    chk("mr req_ready", {31'b0, bus.req_ready_o}, 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr ready_after", {31'b0, bus.req_ready_o}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mr%0d no_rsp", k), {31'b0, bus.rsp_valid_o}, 32'd0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_access_seq.md
Name: csr_access_seq

Overview:
- Sequencer between the decode/execute stage and the CSR register unit; runs one CSR instruction per transaction as a read-then-write access.
- Accepts CSRRW/RS/RC/RWI/RSI/RCI requests over a valid/ready handshake.
- Reads the old CSR value, then issues at most one write strobe to the CSR unit with the correct op code.
- Returns the old value for rd writeback over a second valid/ready handshake.

Parameters:
CSR_ADDR_W, 12, CSR address width
DATA_W, 32, CSR and register data width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  CSR instruction request valid
req_ready_o  out  1  sequencer can accept a request
req_funct3_i  in  3  instr[14:12]
req_csr_addr_i  in  CSR_ADDR_W  instr[31:20]
req_rs1_field_i  in  5  instr[19:15]; used as zimm and as the zero test
req_rs1_data_i  in  DATA_W  rs1 register value
req_rd_i  in  5  destination register
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_rd_o  out  5  latched rd
rsp_rdata_o  out  DATA_W  old CSR value
rsp_wen_o  out  1  rd writeback enable; 1 iff legal and rd!=0
rsp_illegal_o  out  1  illegal-instruction flag
csr_addr_o  out  CSR_ADDR_W  address to CSR unit
csr_wdata_o  out  DATA_W  operand to CSR unit
csr_op_o  out  2  00 RW, 01 RS, 10 RC
csr_we_o  out  1  single-cycle write strobe
csr_rdata_i  in  DATA_W  combinational read data from CSR unit

Behaviour:
- Reset: state IDLE, rdy_q=0, all latched fields 0.
  - Every output is 0 while rst_ni is low, including req_ready_o.
  - rdy_q sets on the first clock edge after deassertion.
- req_ready_o = (state==IDLE) & rdy_q.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: on req_valid_i & req_ready_o, latch funct3, addr, rs1_field, rs1_data, rd.
  - Next state is READ, or RESP if funct3 is 000 or 100.
- READ: drive csr_addr_o, csr_we_o=0; capture csr_rdata_i into old_q.
  - Write needed = funct3[1:0]==01 (RW/RWI) or rs1_field!=0.
  - Write needed -> WRITE, else -> RESP.
- WRITE: csr_we_o=1 for exactly one cycle.
  - csr_op_o = funct3[1:0]-1 (01->00, 10->01, 11->10).
  - csr_wdata_o = funct3[2] ? zero-extended rs1_field : rs1_data.
  - Next state RESP.
- RESP: rsp_valid_o=1 with rsp_* stable until rsp_ready_i, then -> IDLE.
  - Legal access: rsp_rdata_o=old_q.
  - Illegal access: rsp_illegal_o=1, rsp_rdata_o=0, rsp_wen_o=0, no CSR access performed.
- csr_addr_o holds the latched address in READ and WRITE, else 0. csr_op_o/csr_wdata_o are 0 outside WRITE.
- Latency from accept edge to rsp_valid_o:
  - 3 cycles with a write.
  - 2 cycles without a write.
  - 1 cycle for illegal funct3.
- No back-to-back acceptance; throughput is at most one request per 3–4 cycles.
- Response backpressure holds the FSM in RESP indefinitely; no new request is accepted meanwhile.
- Reset asserted mid-transaction: csr_we_o drops immediately, the transaction is discarded, no response is produced.
- csr_rdata_i is sampled only in READ; changes in WRITE (e.g. cycle counter) do not affect rsp_rdata_o.

Optional Feature:
- Macro CSR_RO_CHECK_EN.
- Defined: a write-needed access with csr_addr[11:10]==2'b11 is flagged in READ as illegal.
  - Skips WRITE; response has illegal=1, wen=0, rdata=0.
- Undefined: no check; the write strobe is issued and the CSR unit ignores it for read-only registers.

Decomposition:
- Package csr_pkg holds:
  - funct3 encodings CSRRW..CSRRCI.
  - CSR op codes CSR_OP_RW/RS/RC.
  - FSM state encoding.
  - CSR address constants CSR_CYCLE=12'hC00, CSR_CYCLEH=12'hC80.
- One sub-module, csr_decode (combinational): funct3 and rs1_field in -> op, wdata select, write_needed, illegal.

Test Plan:
- CSRRW rd=5, addr C00, rs1_data=0x1234, csr_rdata_i=0x10 -> one csr_we_o pulse with op 00 / wdata 0x1234; rsp 3 cycles after accept with rdata=0x10, rd=5, wen=1.
- CSRRS rs1_field=0, rd=3 -> csr_we_o never asserts; rsp at cycle 2, wen=1.
- CSRRCI zimm=5'h1F -> single we pulse, op 10, wdata 0x0000001F.
- funct3=100 -> rsp at cycle 1: illegal=1, wen=0, rdata=0; csr_addr_o stays 0.
- rsp_ready_i low for 4 cycles -> rsp_valid_o and rsp_* held, req_ready_o=0 throughout; IDLE one cycle after handshake.
- rst_ni low during WRITE -> csr_we_o 0 same cycle, no response; req_ready_o=1 one edge after release.
- With CSR_RO_CHECK_EN, CSRRW to C80 -> illegal=1, no we; without the macro -> we pulse issued.
